// File: rtl/iomem_button_pkg.sv
// Shared definitions for the iomem button/sense capture peripheral:
// register offsets, bus FSM encoding and a strobe-to-bitmask helper.
package iomem_button_pkg;

   localparam logic [7:0] OFF_LEVEL    = 8'h00;
   localparam logic [7:0] OFF_RISE     = 8'h04;
   localparam logic [7:0] OFF_FALL     = 8'h08;
   localparam logic [7:0] OFF_RISE_EN  = 8'h0C;
   localparam logic [7:0] OFF_FALL_EN  = 8'h10;
   localparam logic [7:0] OFF_DEBOUNCE = 8'h14;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } bus_state_e;

   function automatic logic [31:0] byte_mask(input logic [3:0] wstrb);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{wstrb[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One input channel: 2-FF synchroniser, debounce counter and a stable level,
// with single-cycle rise/fall indications coincident with the stable update.
module button_debounce_ch #(
   parameter int DEB_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pin_i,
   input  logic [DEB_W-1:0] deb_i,
   output logic             stable_o,
   output logic             rise_o,
   output logic             fall_o
);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;

   // A debounce of 0 or 1 takes the new level on the first differing cycle.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (deb_i <= DEB_W'(1) || cnt_q >= deb_i - DEB_W'(1)) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + DEB_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= pin_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = ~stable_q & stable_d;
   assign fall_o   = stable_q & ~stable_d;

endmodule

// File: rtl/iomem_button_capture.sv
// picosoc iomem peripheral: debounced button/sense inputs with sticky W1C edge
// pending registers, per-edge enables and a registered level interrupt.
module iomem_button_capture
   import iomem_button_pkg::*;
#(
   parameter int               N_IN      = 4,
   parameter logic [7:0]       BASE_ADDR = 8'h0A,
   parameter int               DEB_W     = 16,
   parameter logic [DEB_W-1:0] DEB_RESET = 16'd12000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_IN-1:0] pins,
   input  logic            iomem_valid,
   input  logic [3:0]      iomem_wstrb,
   input  logic [31:0]     iomem_addr,
   input  logic [31:0]     iomem_wdata,
   output logic            iomem_ready,
   output logic [31:0]     iomem_rdata,
   output logic            irq,
   output bus_state_e      dbg_state_o
);

   logic [N_IN-1:0]  stable, rise, fall;
   logic [N_IN-1:0]  rise_pend_q, rise_pend_d, fall_pend_q, fall_pend_d;
   logic [N_IN-1:0]  rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic             ready_q, ready_d, irq_q, irq_d;
   logic [31:0]      rdata_q, rdata_d, rd_val, bmask;
   logic [N_IN-1:0]  wsel, wbits;
   logic             sel;
   bus_state_e       state_q, state_d;
   logic             unused_bits;

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
      button_debounce_ch #(.DEB_W(DEB_W)) u_ch (
         .clk      (clk),
         .reset    (reset),
         .pin_i    (pins[gi]),
         .deb_i    (deb_q),
         .stable_o (stable[gi]),
         .rise_o   (rise[gi]),
         .fall_o   (fall[gi])
      );
   end

   assign bmask = byte_mask(iomem_wstrb);
   assign wsel  = bmask[N_IN-1:0];
   assign wbits = iomem_wdata[N_IN-1:0] & wsel;
   assign sel   = iomem_valid && (iomem_addr[31:24] == BASE_ADDR) && !ready_q;

   always_comb begin
      rd_val = '0;
      case (iomem_addr[7:0])
         OFF_LEVEL:    rd_val = 32'(stable);
         OFF_RISE:     rd_val = 32'(rise_pend_q);
         OFF_FALL:     rd_val = 32'(fall_pend_q);
         OFF_RISE_EN:  rd_val = 32'(rise_en_q);
         OFF_FALL_EN:  rd_val = 32'(fall_en_q);
         OFF_DEBOUNCE: rd_val = 32'(deb_q);
         default:      rd_val = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ready_d     = 1'b0;
      rdata_d     = rdata_q;
      rise_pend_d = rise_pend_q;
      fall_pend_d = fall_pend_q;
      rise_en_d   = rise_en_q;
      fall_en_d   = fall_en_q;
      deb_d       = deb_q;
      case (state_q)
         ST_IDLE: begin
            if (sel) begin
               ready_d = 1'b1;
               rdata_d = rd_val;
               state_d = ST_ACK;
               case (iomem_addr[7:0])
                  OFF_RISE:     rise_pend_d = rise_pend_q & ~wbits;
                  OFF_FALL:     fall_pend_d = fall_pend_q & ~wbits;
                  OFF_RISE_EN:  rise_en_d   = (rise_en_q & ~wsel) | wbits;
                  OFF_FALL_EN:  fall_en_d   = (fall_en_q & ~wsel) | wbits;
                  OFF_DEBOUNCE: deb_d       = (deb_q & ~bmask[DEB_W-1:0])
                                            | (iomem_wdata[DEB_W-1:0] & bmask[DEB_W-1:0]);
                  default: ;
               endcase
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Edge sets are applied after the clear so a colliding set survives.
      rise_pend_d = rise_pend_d | rise;
      fall_pend_d = fall_pend_d | fall;
      irq_d = |((rise_pend_q & rise_en_q) | (fall_pend_q & fall_en_q));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         rise_pend_q <= '0;
         fall_pend_q <= '0;
         rise_en_q   <= '0;
         fall_en_q   <= '0;
         deb_q       <= DEB_RESET;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         rise_pend_q <= rise_pend_d;
         fall_pend_q <= fall_pend_d;
         rise_en_q   <= rise_en_d;
         fall_en_q   <= fall_en_d;
         deb_q       <= deb_d;
         irq_q       <= irq_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign irq         = irq_q;
   assign dbg_state_o = state_q;
   assign unused_bits = ^{iomem_addr[23:8], iomem_wdata, bmask};

endmodule
